// File: rtl/spi_rx_unpacker_pkg.sv
// spi_rx_unpacker_pkg: frame header layout and FSM states shared by the
// SPI receive path, this unpacker and the transmit-side packer.
package spi_rx_unpacker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SEND
    } state_t;

    // 32-bit header: {magic, seq, len, flags}
    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 24;
    localparam int SEQ_HI   = 23;
    localparam int SEQ_LO   = 16;
    localparam int LEN_HI   = 15;
    localparam int LEN_LO   = 8;
    localparam int FLAGS_HI = 7;
    localparam int FLAGS_LO = 0;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    localparam int CNT_W = 16;

endpackage

// File: rtl/spi_rx_unpacker_sat_counter.sv
// spi_rx_unpacker_sat_counter: up-counter that sticks at all-ones.
// Ports: clk, rst_n (async low), inc (count enable), count.
module spi_rx_unpacker_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spi_rx_unpacker.sv
// spi_rx_unpacker: takes one {message, header} frame, validates the header,
// streams header + LEN payload bytes MSB first; bad frames are counted.
// Ports: clk_in, rst_n_in (async low); rx_* frame input (valid/ready);
// byte_* output stream (valid/ready/last); frames_ok/dropped counters.
module spi_rx_unpacker
    import spi_rx_unpacker_pkg::*;
#(
    parameter int         MESSAGE_SIZE = 512,
    parameter int         HEADER_SIZE  = 32,
    parameter logic [7:0] MAGIC        = DEFAULT_MAGIC
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [MESSAGE_SIZE-1:0] rx_message_in,
    input  logic [HEADER_SIZE-1:0]  rx_header_in,
    input  logic                    rx_valid_in,
    output logic                    rx_ready_out,
    output logic [7:0]              byte_out,
    output logic                    byte_valid_out,
    input  logic                    byte_ready_in,
    output logic                    byte_last_out,
    output logic [CNT_W-1:0]        frames_ok_out,
    output logic [CNT_W-1:0]        frames_dropped_out
);

    localparam int MAXLEN  = MESSAGE_SIZE / 8;
    localparam int FRAME_W = HEADER_SIZE + MESSAGE_SIZE;
    localparam int IDX_W   = 9;

    state_t                  state_q, state_d;
    logic [HEADER_SIZE-1:0]  hdr_q;
    logic [MESSAGE_SIZE-1:0] msg_q;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
    logic [7:0]              byte_q, byte_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    accept, ok_inc, drop_inc;
    logic [7:0]              len;
    logic                    hdr_ok;
    logic [IDX_W-1:0]        last_idx;
    logic [FRAME_W-1:0]      frame;

    // Header and payload form one big-endian byte string.
    function automatic logic [7:0] pick(
        input logic [FRAME_W-1:0] f,
        input logic [IDX_W-1:0]   idx
    );
        logic [FRAME_W-1:0] sh;
        sh = f << {idx, 3'b000};
        return sh[FRAME_W-1 -: 8];
    endfunction

    assign frame    = {hdr_q, msg_q};
    assign len      = hdr_q[LEN_HI:LEN_LO];
    assign hdr_ok   = (hdr_q[MAGIC_HI:MAGIC_LO] == MAGIC)
                   && (len != 8'd0)
                   && ({1'b0, len} <= IDX_W'(MAXLEN));
    assign last_idx = {1'b0, len} + 9'd3;
    assign idx_nxt  = idx_q + 9'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        last_d   = last_q;
        accept   = 1'b0;
        ok_inc   = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid_in) begin
                    accept  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hdr_ok) begin
                    idx_d   = '0;
                    byte_d  = pick(frame, '0);
                    valid_d = 1'b1;
                    // LEN >= 1, so byte 0 is never the last one
                    last_d  = 1'b0;
                    state_d = SEND;
                end else begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            SEND: begin
                if (valid_q && byte_ready_in) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ok_inc  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_nxt;
                        byte_d = pick(frame, idx_nxt);
                        last_d = (idx_nxt == last_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hdr_q <= '0;
            msg_q <= '0;
        end else if (accept) begin
            hdr_q <= rx_header_in;
            msg_q <= rx_message_in;
        end
    end

    spi_rx_unpacker_sat_counter #(.WIDTH(CNT_W)) u_ok_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (ok_inc),
        .count (frames_ok_out)
    );

    spi_rx_unpacker_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (drop_inc),
        .count (frames_dropped_out)
    );

    assign rx_ready_out   = (state_q == IDLE);
    assign byte_out       = byte_q;
    assign byte_valid_out = valid_q;
    assign byte_last_out  = last_q;

endmodule
